// File: rtl/mac_reduce_acc_pkg.sv
// rtl/mac_reduce_acc_pkg.sv - Q-format defaults, FSM encodings and sizing helper for mac_reduce_acc
package mac_reduce_acc_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FBITS = 24;
  localparam int DEF_N_REG = 31;
  localparam int DEF_LANES = 8;
  localparam int DEF_ACC_W = 48;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REDUCE = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  function automatic int ncyc(input int n_reg, input int lanes);
    return (n_reg + lanes - 1) / lanes;
  endfunction

endpackage

// File: rtl/mac_reduce_acc_sat_q.sv
// rtl/mac_reduce_acc_sat_q.sv - combinational clip of a signed IN_W value to signed WIDTH
module sat_q #(
  parameter int IN_W  = 49,
  parameter int WIDTH = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [WIDTH-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = ~MAXV;

  always_comb begin
    dout = din[WIDTH-1:0];
    sat  = 1'b0;
    if (din > MAXV) begin
      dout = MAXV[WIDTH-1:0];
      sat  = 1'b1;
    end else if (din < MINV) begin
      dout = MINV[WIDTH-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/mac_reduce_acc.sv
// rtl/mac_reduce_acc.sv - lane-group reduce and multi-beat accumulate with bias add and Q saturation
module mac_reduce_acc
  import mac_reduce_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FBITS = DEF_FBITS,
  parameter int N_REG = DEF_N_REG,
  parameter int LANES = DEF_LANES,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [N_REG*WIDTH-1:0] all_mult,
  input  logic [WIDTH-1:0]       bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_sat
);

  localparam int NCYC  = ncyc(N_REG, LANES);
  localparam int NPAD  = NCYC * LANES;
  localparam int IDX_W = $clog2(NPAD + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPAD - LANES);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

  logic [1:0]              state;
  logic [N_REG*WIDTH-1:0]  mult_q;
  logic                    last_q;
  logic [WIDTH-1:0]        bias_q;
  logic [IDX_W-1:0]        lane_idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] grp_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W:0]   s;
  logic [WIDTH-1:0]        sat_data;
  logic                    sat_flag;
  logic signed [ACC_W-1:0] terms [LANES];

  // The lane buffer shifts down one group per REDUCE cycle, so the adder always sees its low LANES lanes.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    if (k < N_REG) begin : g_live
      assign terms[k] = ACC_W'($signed(mult_q[k*WIDTH +: WIDTH]));
    end else begin : g_pad
      assign terms[k] = '0;
    end
  end

  always_comb begin
    grp_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      grp_sum = grp_sum + terms[i];
    end
  end

  assign acc_next = acc + grp_sum;
  assign s        = (ACC_W+1)'(acc_next) + (ACC_W+1)'($signed(bias_q));

  // A degenerate Q format has no representable range, so every result is reported as clipped.
  if (FBITS < WIDTH && ACC_W >= WIDTH) begin : g_sat
    sat_q #(.IN_W(ACC_W+1), .WIDTH(WIDTH)) u_sat (
      .din  (s),
      .dout (sat_data),
      .sat  (sat_flag)
    );
  end else begin : g_bad_fmt
    assign sat_data = '0;
    assign sat_flag = 1'b1;
  end

  assign in_ready = rst_n && (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      lane_idx  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mult_q   <= all_mult;
            last_q   <= in_last;
            if (in_last) bias_q <= bias;
            lane_idx <= '0;
            state    <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          acc      <= acc_next;
          mult_q   <= mult_q >> (LANES * WIDTH);
          lane_idx <= lane_idx + IDX_STEP;
          if (lane_idx == IDX_LAST) begin
            if (last_q) begin
              out_valid <= 1'b1;
              out_data  <= sat_data;
              out_sat   <= sat_flag;
              state     <= ST_OUT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_reduce_acc.sv
// tb/tb_mac_reduce_acc.sv - randomized bench for mac_reduce_acc against a behavioural dot-product model
module tb_mac_reduce_acc;

  localparam int WIDTH = 32;
  localparam int N_REG = 31;
  localparam int NCYC  = 4;
  localparam longint QMAX = 64'sd2147483647;
  localparam longint QMIN = -64'sd2147483648;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [N_REG*WIDTH-1:0] all_mult;
  logic [WIDTH-1:0]       bias;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic                   out_sat;

  mac_reduce_acc #(.WIDTH(32), .FBITS(24), .N_REG(31), .LANES(8), .ACC_W(48)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .all_mult(all_mult), .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    int          vcyc;
  } exp_t;

  exp_t        expq[$];
  longint      acc_m = 0;
  int          reduce_end = 0;
  int          checks = 0;
  int          failures = 0;
  int          n_out = 0;
  int          total = 0;
  int          last_accept = 0;
  int          first_valid_cyc = 0;
  logic [31:0] last_data = '0;
  logic        last_sat = 1'b0;
  logic        prev_ov = 1'b0;
  bit          started = 0;
  int          rdy_mode = 2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N_REG*WIDTH-1:0] fill(input logic [31:0] v);
    logic [N_REG*WIDTH-1:0] m;
    for (int g = 0; g < N_REG; g++) m[g*WIDTH +: WIDTH] = v;
    return m;
  endfunction

  // Dot-product model: plain integer sums of every lane, clip only at the end of the last beat.
  task automatic model_accept(input logic [N_REG*WIDTH-1:0] m, input logic last, input logic [31:0] b,
                              input int acc_cyc);
    exp_t   e;
    longint sv;
    for (int g = 0; g < N_REG; g++) acc_m += longint'($signed(m[g*WIDTH +: WIDTH]));
    reduce_end  = acc_cyc + NCYC;
    last_accept = acc_cyc;
    if (last) begin
      sv = acc_m + longint'($signed(b));
      if (sv > QMAX) begin e.data = 32'h7FFFFFFF; e.sat = 1'b1; end
      else if (sv < QMIN) begin e.data = 32'h80000000; e.sat = 1'b1; end
      else begin e.data = sv[31:0]; e.sat = 1'b0; end
      e.vcyc = acc_cyc + NCYC;
      expq.push_back(e);
      total++;
      acc_m = 0;
    end
  endtask

  task automatic send_beat(input logic [N_REG*WIDTH-1:0] m, input logic last, input logic [31:0] b);
    int acc_cyc;
    bit done;
    done = 0;
    @(negedge clk);
    for (int t = 0; t < 300 && !done; t++) begin
      in_valid = 1'b1;
      if (in_ready) begin
        all_mult = m;
        in_last  = last;
        bias     = b;
        acc_cyc  = cyc + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        all_mult = fill($urandom());
        bias     = $urandom();
        model_accept(m, last, b, acc_cyc);
        done = 1;
      end else begin
        all_mult = fill($urandom());
        in_last  = 1'($urandom());
        bias     = $urandom();
        @(negedge clk);
      end
    end
    if (!done) begin
      in_valid = 1'b0;
      check("send_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (n_out < target && t < 600) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("out_count", 64'(n_out), 64'(target));
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    logic ev, er;
    if (started) begin
      ev = rst_n && (expq.size() > 0) && (cyc >= expq[0].vcyc);
      er = rst_n && (expq.size() == 0) && (cyc >= reduce_end);
      check("out_valid", 64'(out_valid), 64'(ev));
      check("in_ready", 64'(in_ready), 64'(er));
      if (ev && out_valid) begin
        check("out_data", 64'(out_data), 64'(expq[0].data));
        check("out_sat", 64'(out_sat), 64'(expq[0].sat));
        if (out_ready) begin
          last_data = out_data;
          last_sat  = out_sat;
          void'(expq.pop_front());
          n_out++;
        end
      end
      if (out_valid && !prev_ov) first_valid_cyc = cyc;
      prev_ov = out_valid;
    end
  end

  initial begin
    logic [N_REG*WIDTH-1:0] m;
    logic [31:0]            v;
    int                     nb;
    int                     r;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; all_mult = '0; bias = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    started = 1;
    @(posedge clk); #1; rst_n = 1'b1;

    send_beat(fill(32'h01000000), 1'b1, 32'h0);
    wait_out(total);
    check("t1_data", 64'(last_data), 64'h1F000000);
    check("t1_sat", 64'(last_sat), 64'd0);
    check("t1_latency", 64'(first_valid_cyc - last_accept), 64'd4);

    m = '0;
    m[31:0] = 32'h00800000;
    r = n_out;
    send_beat(m, 1'b0, 32'h0);
    send_beat(m, 1'b0, 32'h0);
    repeat (NCYC + 2) @(negedge clk);
    check("t2_no_early_out", 64'(n_out), 64'(r));
    send_beat(m, 1'b1, 32'hFF000000);
    wait_out(total);
    check("t2_data", 64'(last_data), 64'h00800000);

    send_beat(fill(32'h7FFFFFFF), 1'b1, 32'h0);
    wait_out(total);
    check("t3_pos_data", 64'(last_data), 64'h7FFFFFFF);
    check("t3_pos_sat", 64'(last_sat), 64'd1);
    send_beat(fill(32'h80000000), 1'b1, 32'h0);
    wait_out(total);
    check("t3_neg_data", 64'(last_data), 64'h80000000);
    check("t3_neg_sat", 64'(last_sat), 64'd1);

    rdy_mode = 1;
    send_beat(fill(32'h01000000), 1'b1, 32'h0);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    fork
      send_beat('0, 1'b1, 32'h0);
      begin
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          check("t4_hold_valid", 64'(out_valid), 64'd1);
          check("t4_hold_data", 64'(out_data), 64'h1F000000);
        end
        rdy_mode = 2;
      end
    join
    wait_out(total);
    check("t4_zero_data", 64'(last_data), 64'h0);

    send_beat(fill(32'h01000000), 1'b1, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    expq.delete();
    acc_m = 0;
    reduce_end = 0;
    total = n_out;
    @(negedge clk);
    check("t5_rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t5_rst_valid", 64'(out_valid), 64'd0);
    check("t5_rst_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_beat(fill(32'h01000000), 1'b1, 32'h0);
    wait_out(total);
    check("t5_post_data", 64'(last_data), 64'h1F000000);

    rdy_mode = 0;
    for (int t = 0; t < 40; t++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        for (int g = 0; g < N_REG; g++) begin
          if (t % 5 == 4) v = $urandom();
          else begin
            r = int'($urandom_range(0, 268435455)) - 134217728;
            v = r;
          end
          m[g*WIDTH +: WIDTH] = v;
        end
        send_beat(m, (b == nb - 1), (t % 3 == 0) ? $urandom() : 32'($signed(int'($urandom_range(0, 65535)) - 32768)));
      end
    end
    rdy_mode = 2;
    wait_out(total);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
